// File: rtl/phase_vector_sequencer_pkg.sv
// Shared types for the phase-vector sequencer: FSM states, batch sizing and the
// ordered index pair handed to the cofactor merge stage.
package cofactor_pkg;

   localparam int NUM_QUBIT = 3;
   localparam int DEPTH     = 2**NUM_QUBIT;

   typedef enum logic [2:0] {
      LOAD   = 3'd0,
      ROUND1 = 3'd1,
      WAIT   = 3'd2,
      ROUND2 = 3'd3,
      DRAIN  = 3'd4
   } state_t;

   typedef struct packed {
      logic [NUM_QUBIT-1:0] first;
      logic [NUM_QUBIT-1:0] second;
   } pair_t;

endpackage

// File: rtl/phase_vector_sequencer_buffer.sv
// Batch storage for phase vectors: synchronous write port, asynchronous read port.
module phase_buffer
   import cofactor_pkg::*;
#(
   parameter int addr_w = NUM_QUBIT,
   parameter int data_w = NUM_QUBIT
) (
   input  logic              clk,
   input  logic              we,
   input  logic [addr_w-1:0] waddr,
   input  logic [data_w-1:0] wdata,
   input  logic [addr_w-1:0] raddr,
   output logic [data_w-1:0] rdata
);

   logic [data_w-1:0] mem [2**addr_w];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/phase_vector_sequencer.sv
// Buffers a batch of phase vectors, plays it out as round-1 index writes and a
// round-2 replay, and turns returned partner hits into ordered index pairs.
module phase_vector_sequencer
   import cofactor_pkg::*;
#(
   parameter int num_qubit = NUM_QUBIT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 in_phase [0:num_qubit-1],
   input  logic                 in_last,
   output logic                 in_ready,
   input  logic                 done_alpha,
   output logic                 ori_phase_vector [0:num_qubit-1],
   output logic                 valid_ori_phase_write,
   input  logic                 valid_second_round,
   input  logic                 output_valid,
   input  logic [num_qubit-1:0] output_index,
   output logic                 pair_valid,
   output logic [num_qubit-1:0] pair_first,
   output logic [num_qubit-1:0] pair_second,
   output logic                 batch_done,
   output logic                 overflow,
   output logic [2:0]           fsm_state
);

   localparam logic [num_qubit:0] depth_c = (num_qubit+1)'(2**num_qubit);
   localparam logic [31:0]        tc_max  = 32'(2**num_qubit);

   state_t               state;
   logic [num_qubit:0]   count;
   logic [num_qubit:0]   k;
   logic [31:0]          tc;
   logic                 alpha_seen;
   logic                 drain_cnt;
   logic [num_qubit-1:0] ori_vec;
   logic [num_qubit-1:0] drv_idx;
   logic [num_qubit-1:0] prev_idx;
   logic [num_qubit-1:0] in_vec;
   logic [num_qubit-1:0] rd_vec;
   logic                 buf_we;

   // Array element i maps to packed bit num_qubit-1-i (element 0 is the MSB).
   for (genvar gi = 0; gi < num_qubit; gi++) begin : g_map
      assign in_vec[num_qubit-1-gi]  = in_phase[gi];
      assign ori_phase_vector[gi]    = ori_vec[num_qubit-1-gi];
   end

   assign fsm_state = state;
   assign buf_we    = (state == LOAD) && in_valid && (count < depth_c);

   phase_buffer #(.addr_w(num_qubit), .data_w(num_qubit)) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (count[num_qubit-1:0]),
      .wdata (in_vec),
      .raddr (k[num_qubit-1:0]),
      .rdata (rd_vec)
   );

   // Handshake: a vector is taken on every clock where in_valid and in_ready are both
   // high; in_valid while the batch is full (and not flagged last) is dropped and
   // sets the sticky overflow flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                 <= LOAD;
         count                 <= '0;
         k                     <= '0;
         tc                    <= '0;
         alpha_seen            <= 1'b0;
         drain_cnt             <= 1'b0;
         ori_vec               <= '0;
         drv_idx               <= '0;
         valid_ori_phase_write <= 1'b0;
         in_ready              <= 1'b1;
         batch_done            <= 1'b0;
         overflow              <= 1'b0;
      end else begin
         batch_done <= 1'b0;
         if (in_valid && !in_last && (count == depth_c)) begin
            overflow <= 1'b1;
         end
         case (state)
            LOAD: begin
               if (buf_we) begin
                  count <= count + 1'b1;
                  if (in_last || (count == depth_c - 1'b1)) begin
                     state    <= ROUND1;
                     in_ready <= 1'b0;
                     k        <= '0;
                  end
               end
            end
            ROUND1: begin
               if (k < count) begin
                  ori_vec               <= rd_vec;
                  valid_ori_phase_write <= 1'b1;
                  k                     <= k + 1'b1;
                  tc                    <= (k == '0) ? 32'd1 : ((tc < tc_max) ? tc + 32'd1 : tc);
               end else begin
                  ori_vec               <= '0;
                  valid_ori_phase_write <= 1'b0;
                  k                     <= '0;
                  tc                    <= (tc < tc_max) ? tc + 32'd1 : tc;
                  alpha_seen            <= 1'b0;
                  state                 <= WAIT;
               end
            end
            WAIT: begin
               tc <= (tc < tc_max) ? tc + 32'd1 : tc;
               if (done_alpha) begin
                  alpha_seen <= 1'b1;
               end
               // k is 0 here, so rd_vec already presents the first buffered vector.
               if ((tc >= tc_max) && (done_alpha || alpha_seen)) begin
                  state   <= ROUND2;
                  ori_vec <= rd_vec;
                  drv_idx <= '0;
                  k       <= (num_qubit+1)'(1);
               end
            end
            ROUND2: begin
               if (k < count) begin
                  ori_vec <= rd_vec;
                  drv_idx <= k[num_qubit-1:0];
                  k       <= k + 1'b1;
               end else if (k == count) begin
                  k <= k + 1'b1;
               end else begin
                  ori_vec   <= '0;
                  drain_cnt <= 1'b0;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               if (!drain_cnt) begin
                  drain_cnt <= 1'b1;
               end else begin
                  state      <= LOAD;
                  count      <= '0;
                  k          <= '0;
                  tc         <= '0;
                  in_ready   <= 1'b1;
                  batch_done <= 1'b1;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   // The index RAM answers one cycle after it sees a vector, so a hit belongs to the
   // vector driven on the previous cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_idx    <= '0;
         pair_valid  <= 1'b0;
         pair_first  <= '0;
         pair_second <= '0;
      end else begin
         prev_idx   <= drv_idx;
         pair_valid <= 1'b0;
         if (valid_second_round && output_valid && (prev_idx != output_index)) begin
            pair_valid <= 1'b1;
            if (prev_idx < output_index) begin
               pair_first  <= prev_idx;
               pair_second <= output_index;
            end else begin
               pair_first  <= output_index;
               pair_second <= prev_idx;
            end
         end
      end
   end

endmodule
